coin_pulse_emitter: RTL

COIN_PULSE_EMITTER -- requirements
Module: coin_pulse_emitter

---
 rtl/coin_pulse_emitter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/coin_pulse_emitter.sv
// =====================================================================
// coin_pulse_emitter: per accepted request, emits N low pulses on an idle-high
// line followed by a high guard period. Macro COIN_EMITTER_PENDING_EN adds a
// one-entry pending request buffer.                       Revision: 1.0
// =====================================================================
`default_nettype none

module coin_pulse_emitter #(
  parameter int MAX_PULSE_COUNT   = 50,
  parameter int PULSE_LOW_CYCLES  = 600_000,
  parameter int PULSE_HIGH_CYCLES = 600_000,
  parameter int GUARD_CYCLES      = 4_000_000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [$clog2(MAX_PULSE_COUNT)-1:0] coin_in,
  input  logic                               coin_valid,
  output logic                               coin_ready,
  output logic                               pulse_out,
  output logic                               busy_out,
  output logic                               done_out
);

  localparam int c_rw     = $clog2(MAX_PULSE_COUNT + 1);
  localparam int c_tmax_a = (PULSE_LOW_CYCLES > PULSE_HIGH_CYCLES) ? PULSE_LOW_CYCLES
                                                                   : PULSE_HIGH_CYCLES;
  localparam int c_tmax   = (c_tmax_a > GUARD_CYCLES) ? c_tmax_a : GUARD_CYCLES;
  localparam int c_pw     = $clog2(c_tmax) + 1;

  localparam logic [c_pw-1:0] c_low_load   = c_pw'(PULSE_LOW_CYCLES - 1);
  localparam logic [c_pw-1:0] c_high_load  = c_pw'(PULSE_HIGH_CYCLES - 1);
  localparam logic [c_pw-1:0] c_guard_load = c_pw'(GUARD_CYCLES - 1);
  localparam logic [c_pw-1:0] c_phase_one  = c_pw'(1);
  localparam logic [c_rw-1:0] c_max_cnt    = c_rw'(MAX_PULSE_COUNT);
  localparam logic [c_rw-1:0] c_cnt_one    = c_rw'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOW   = 2'd1,
    HIGH  = 2'd2,
    GUARD = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [c_pw-1:0] phase_q, phase_d;
  logic [c_rw-1:0] remain_q, remain_d;
  logic            pulse_q, pulse_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;

  logic            accept;
  logic            start;
  logic [c_rw-1:0] clamped;
  logic [c_rw-1:0] start_cnt;

`ifdef COIN_EMITTER_PENDING_EN
  logic            pend_valid_q, pend_valid_d;
  logic [c_rw-1:0] pend_cnt_q, pend_cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    remain_d  = remain_q;
    done_d    = 1'b0;
    start     = 1'b0;
    accept    = coin_valid && ready_q;
    clamped   = (c_rw'(coin_in) > c_max_cnt) ? c_max_cnt : c_rw'(coin_in);
    start_cnt = clamped;
`ifdef COIN_EMITTER_PENDING_EN
    pend_valid_d = pend_valid_q;
    pend_cnt_d   = pend_cnt_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef COIN_EMITTER_PENDING_EN
        if (pend_valid_q) begin
          start        = 1'b1;
          start_cnt    = pend_cnt_q;
          pend_valid_d = 1'b0;
        end else
`endif
        if (accept && (clamped != '0)) begin
          start = 1'b1;
        end
      end
      LOW: begin
        if (phase_q == '0) begin
          // remain_q still counts the pulse now finishing
          remain_d = (remain_q != '0) ? (remain_q - c_cnt_one) : '0;
          if (remain_q > c_cnt_one) begin
            state_d = HIGH;
            phase_d = c_high_load;
          end else begin
            state_d = GUARD;
            phase_d = c_guard_load;
          end
        end else begin
          phase_d = phase_q - c_phase_one;
        end
      end
      HIGH: begin
        if (phase_q == '0) begin
          state_d = LOW;
          phase_d = c_low_load;
        end else begin
          phase_d = phase_q - c_phase_one;
        end
      end
      GUARD: begin
        if (phase_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          phase_d = phase_q - c_phase_one;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d  = LOW;
      phase_d  = c_low_load;
      remain_d = start_cnt;
    end

`ifdef COIN_EMITTER_PENDING_EN
    if (accept && (state_q != IDLE) && (clamped != '0)) begin
      pend_valid_d = 1'b1;
      pend_cnt_d   = clamped;
    end
    ready_d = !pend_valid_d;
`else
    ready_d = (state_d == IDLE);
`endif
    pulse_d = (state_d != LOW);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      remain_q <= '0;
      pulse_q  <= 1'b1;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
`ifdef COIN_EMITTER_PENDING_EN
      pend_valid_q <= 1'b0;
      pend_cnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      remain_q <= remain_d;
      pulse_q  <= pulse_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
`ifdef COIN_EMITTER_PENDING_EN
      pend_valid_q <= pend_valid_d;
      pend_cnt_q   <= pend_cnt_d;
`endif
    end
  end

  assign coin_ready = ready_q;
  assign pulse_out  = pulse_q;
  assign busy_out   = busy_q;
  assign done_out   = done_q;

endmodule

`default_nettype wire
